// File: rtl/posit_pkg.sv
// Shared posit definitions: decoder FSM states, regime width helper and special-value patterns.
package posit_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StRegime,
        StExp,
        StFrac,
        StDone
    } state_e;

    // Signed regime width: must hold k in [-(n-2), n-2].
    function automatic int unsigned posit_kw(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

    function automatic logic [63:0] posit_zero(input int unsigned n);
        return 64'd0 & ((64'd1 << n) - 64'd1);
    endfunction

    function automatic logic [63:0] posit_nar(input int unsigned n);
        return 64'd1 << (n - 1);
    endfunction

endpackage

// File: rtl/posit_unpack_n_if.sv
// Handshake and result bundle between a posit producer/consumer and the unpacker.
interface posit_unpack_n_if #(
    parameter int unsigned N  = 32,
    parameter int unsigned ES = 2,
    parameter int unsigned KW = posit_pkg::posit_kw(N)
);
    logic                   in_valid;
    logic                   in_ready;
    logic [N-1:0]           posit_in;
    logic                   out_valid;
    logic                   out_ready;
    logic                   sign;
    logic                   zero;
    logic                   nar;
    logic signed [KW-1:0]   k;
    logic [ES-1:0]          exp;
    logic [N-1:0]           frac;
    logic signed [KW+ES-1:0] scale;

    modport master (
        output in_valid, posit_in, out_ready,
        input  in_ready, out_valid, sign, zero, nar, k, exp, frac, scale
    );

    modport slave (
        input  in_valid, posit_in, out_ready,
        output in_ready, out_valid, sign, zero, nar, k, exp, frac, scale
    );
endinterface

// File: rtl/posit_unpack_n.sv
// Iterative posit<N,ES> decoder: scans the regime one bit per cycle, then extracts
// exponent, hidden-bit fraction and combined scale behind a valid/ready handshake.
module posit_unpack_n
    import posit_pkg::*;
#(
    parameter int unsigned N  = 32,
    parameter int unsigned ES = 2,
    parameter int unsigned KW = posit_kw(N)
) (
    input logic             clk,
    input logic             rst,
    posit_unpack_n_if.slave bus
);

    localparam logic [N-1:0] ZeroPat = N'(posit_zero(N));
    localparam logic [N-1:0] NarPat  = N'(posit_nar(N));

    state_e                  state_q, state_d;
    logic [N-1:0]            p_hold_q;
    logic [KW-1:0]           rem_q;
    logic [KW-1:0]           run_q;
    logic                    rbit_q;
    logic                    sign_q;
    logic                    zero_q;
    logic                    nar_q;
    logic signed [KW-1:0]    k_q;
    logic [ES-1:0]           exp_q;
    logic [N-1:0]            frac_q;
    logic signed [KW+ES-1:0] scale_q;

    logic                    special;
    logic                    top_bit;
    logic                    regime_end;
    logic [N-1:0]            p_abs;
    logic [KW-1:0]           exp_bits;

    always_comb begin
        special    = (p_hold_q == ZeroPat) || (p_hold_q == NarPat);
        p_abs      = p_hold_q[N-1] ? (~p_hold_q + N'(1)) : p_hold_q;
        top_bit    = p_hold_q[N-1];
        // Stop on a terminator, or when the last remaining bit is consumed as part of the run.
        regime_end = (top_bit != rbit_q) || (rem_q == KW'(1));
        exp_bits   = (rem_q < KW'(ES)) ? rem_q : KW'(ES);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (bus.in_valid) state_d = StCheck;
            StCheck:  state_d = special ? StDone : StRegime;
            StRegime: if (regime_end) state_d = StExp;
            StExp:    state_d = StFrac;
            StFrac:   state_d = StDone;
            StDone:   if (bus.out_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_hold_q <= '0;
            rem_q    <= '0;
            run_q    <= '0;
            rbit_q   <= 1'b0;
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
            nar_q    <= 1'b0;
            k_q      <= '0;
            exp_q    <= '0;
            frac_q   <= '0;
            scale_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        p_hold_q <= bus.posit_in;
                        sign_q   <= 1'b0;
                        zero_q   <= 1'b0;
                        nar_q    <= 1'b0;
                        k_q      <= '0;
                        exp_q    <= '0;
                        frac_q   <= '0;
                        scale_q  <= '0;
                    end
                end
                StCheck: begin
                    sign_q <= p_hold_q[N-1];
                    if (special) begin
                        zero_q <= ~p_hold_q[N-1];
                        nar_q  <= p_hold_q[N-1];
                    end else begin
                        p_hold_q <= p_abs << 1;
                        rem_q    <= KW'(N - 1);
                        run_q    <= '0;
                        rbit_q   <= p_abs[N-2];
                    end
                end
                StRegime: begin
                    p_hold_q <= p_hold_q << 1;
                    rem_q    <= rem_q - KW'(1);
                    if (top_bit == rbit_q) run_q <= run_q + KW'(1);
                end
                StExp: begin
                    // Bits past rem are already zero, so a short exponent is zero-padded for free.
                    exp_q    <= p_hold_q[N-1 -: ES];
                    p_hold_q <= p_hold_q << exp_bits;
                    rem_q    <= rem_q - exp_bits;
                    k_q      <= rbit_q ? $signed(run_q - KW'(1)) : $signed(KW'(0) - run_q);
                end
                StFrac: begin
                    frac_q  <= {1'b1, p_hold_q[N-1:1]};
                    scale_q <= ($signed({{ES{k_q[KW-1]}}, k_q}) <<< ES)
                             + $signed({{KW{1'b0}}, exp_q});
                end
                default: ;
            endcase
        end
    end

    assign bus.sign  = sign_q;
    assign bus.zero  = zero_q;
    assign bus.nar   = nar_q;
    assign bus.k     = k_q;
    assign bus.exp   = exp_q;
    assign bus.frac  = frac_q;
    assign bus.scale = scale_q;

endmodule

// File: tb/tb_posit_unpack_n.sv
// Bench for posit_unpack_n at <32,2> and <16,1>: directed vectors, random vectors
// against a reference decoder, DONE back-pressure and mid-scan reset.
module tb_posit_unpack_n;
    import posit_pkg::*;

    typedef struct {
        logic        sign;
        logic        zero;
        logic        nar;
        int          k;
        int          e;
        logic [63:0] frac;
        int          scale;
        int          lat;
    } res_t;

    typedef struct {
        int          sel;
        logic [63:0] p;
        res_t        r;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    posit_unpack_n_if #(.N(32), .ES(2)) if32 ();
    posit_unpack_n_if #(.N(16), .ES(1)) if16 ();

    posit_unpack_n #(.N(32), .ES(2)) dut32 (.clk(clk), .rst(rst), .bus(if32));
    posit_unpack_n #(.N(16), .ES(1)) dut16 (.clk(clk), .rst(rst), .bus(if16));

    // Reference: walk the bit string of |p| directly.
    function automatic res_t ref_decode(input logic [63:0] p_in, input int n, input int es);
        res_t        r;
        logic [63:0] mask, p, v;
        int          i, run, pos;
        logic        rb;
        r.sign = 1'b0; r.zero = 1'b0; r.nar = 1'b0; r.k = 0; r.e = 0;
        r.frac = 64'd0; r.scale = 0; r.lat = 0;
        mask   = (64'd1 << n) - 64'd1;
        p      = p_in & mask;
        r.sign = p[n-1];
        if ((p & (mask >> 1)) == 64'd0) begin
            r.zero = !r.sign;
            r.nar  = r.sign;
            r.lat  = 2;
            return r;
        end
        v   = r.sign ? ((~p + 64'd1) & mask) : p;
        i   = n - 2;
        rb  = v[i];
        run = 0;
        while (i >= 0 && v[i] == rb) begin
            run++;
            i--;
        end
        if (i >= 0) begin
            r.lat = run + 1 + 4;
            i--;
        end else begin
            r.lat = n - 1 + 4;
        end
        r.k = rb ? run - 1 : -run;
        for (int j = 0; j < es; j++) begin
            r.e = r.e * 2 + ((i >= 0) ? int'(v[i]) : 0);
            i--;
        end
        r.frac = 64'd1 << (n - 1);
        pos    = n - 2;
        while (i >= 0) begin
            r.frac[pos] = v[i];
            pos--;
            i--;
        end
        r.scale = r.k * (1 << es) + r.e;
        return r;
    endfunction

    function automatic vec_t mk(input int sel, input logic [63:0] p, input logic s,
                                input logic z, input logic na, input int k, input int e,
                                input logic [63:0] frac, input int scale, input int lat);
        vec_t v;
        v.sel = sel; v.p = p;
        v.r.sign = s; v.r.zero = z; v.r.nar = na; v.r.k = k; v.r.e = e;
        v.r.frac = frac; v.r.scale = scale; v.r.lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input longint got, input longint want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [63:0] p, input logic rdy);
        if (sel == 0) begin
            if32.in_valid = v; if32.posit_in = p[31:0]; if32.out_ready = rdy;
        end else begin
            if16.in_valid = v; if16.posit_in = p[15:0]; if16.out_ready = rdy;
        end
    endtask

    task automatic sample(input int sel, output res_t r, output logic ov, output logic ir);
        r.lat = 0;
        if (sel == 0) begin
            r.sign = if32.sign; r.zero = if32.zero; r.nar = if32.nar;
            r.k = int'(if32.k); r.e = int'(if32.exp); r.frac = 64'(if32.frac);
            r.scale = int'(if32.scale); ov = if32.out_valid; ir = if32.in_ready;
        end else begin
            r.sign = if16.sign; r.zero = if16.zero; r.nar = if16.nar;
            r.k = int'(if16.k); r.e = int'(if16.exp); r.frac = 64'(if16.frac);
            r.scale = int'(if16.scale); ov = if16.out_valid; ir = if16.in_ready;
        end
    endtask

    task automatic cmp_fields(input string tag, input res_t got, input res_t want);
        check({tag, " sign"}, longint'(got.sign), longint'(want.sign));
        check({tag, " zero"}, longint'(got.zero), longint'(want.zero));
        check({tag, " nar"}, longint'(got.nar), longint'(want.nar));
        check({tag, " k"}, longint'(got.k), longint'(want.k));
        check({tag, " exp"}, longint'(got.e), longint'(want.e));
        check({tag, " frac"}, longint'(got.frac), longint'(want.frac));
        check({tag, " scale"}, longint'(got.scale), longint'(want.scale));
    endtask

    task automatic run_vec(input int sel, input logic [63:0] p, input res_t want,
                           input bit early, input int hold, input string tag);
        res_t got;
        logic ov, ir;
        int   lat;
        @(negedge clk);
        drive(sel, 1'b1, p, early);
        sample(sel, got, ov, ir);
        check({tag, " in_ready before accept"}, longint'(ir), 1);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, p, early);
        lat = 1;
        sample(sel, got, ov, ir);
        while (!ov && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            sample(sel, got, ov, ir);
        end
        check({tag, " latency"}, longint'(lat), longint'(want.lat));
        check({tag, " in_ready in DONE"}, longint'(ir), 0);
        cmp_fields(tag, got, want);
        if (!early) begin
            for (int c = 0; c < hold; c++) begin
                @(posedge clk);
                #1;
                sample(sel, got, ov, ir);
                check({tag, " held out_valid"}, longint'(ov), 1);
                check({tag, " held in_ready"}, longint'(ir), 0);
                check({tag, " held frac"}, longint'(got.frac), longint'(want.frac));
                check({tag, " held k"}, longint'(got.k), longint'(want.k));
                check({tag, " held scale"}, longint'(got.scale), longint'(want.scale));
            end
            @(negedge clk);
            drive(sel, 1'b0, p, 1'b1);
        end
        @(posedge clk);
        #1;
        drive(sel, 1'b0, p, 1'b0);
        sample(sel, got, ov, ir);
        check({tag, " out_valid after handshake"}, longint'(ov), 0);
        check({tag, " in_ready after handshake"}, longint'(ir), 1);
    endtask

    vec_t vecs[9];

    initial begin
        res_t        got, want;
        logic        ov, ir;
        logic [63:0] p;
        int          sel, seen;

        vecs[0] = mk(0, 64'h40000000, 0, 0, 0,   0, 0, 64'h80000000,    0,  6);
        vecs[1] = mk(0, 64'h00000000, 0, 1, 0,   0, 0, 64'h00000000,    0,  2);
        vecs[2] = mk(0, 64'h80000000, 1, 0, 1,   0, 0, 64'h00000000,    0,  2);
        vecs[3] = mk(0, 64'h4C000000, 0, 0, 0,   0, 1, 64'hC0000000,    1,  6);
        vecs[4] = mk(0, 64'hB4000000, 1, 0, 0,   0, 1, 64'hC0000000,    1,  6);
        vecs[5] = mk(0, 64'h7FFFFFFF, 0, 0, 0,  30, 0, 64'h80000000,  120, 35);
        vecs[6] = mk(0, 64'h00000001, 0, 0, 0, -30, 0, 64'h80000000, -120, 35);
        vecs[7] = mk(1, 64'h7FFF,     0, 0, 0,  14, 0, 64'h8000,       28, 19);
        vecs[8] = mk(1, 64'h5000,     0, 0, 0,   0, 1, 64'h8000,        1,  6);

        // Reset: in_ready stays high and nothing is captured while rst is asserted.
        drive(0, 1'b1, 64'h40000000, 1'b0);
        drive(1, 1'b0, 64'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        sample(0, got, ov, ir);
        check("reset in_ready", longint'(ir), 1);
        check("reset out_valid", longint'(ov), 0);
        want = ref_decode(64'h0, 32, 2);
        want.zero = 1'b0;
        cmp_fields("reset", got, want);
        @(negedge clk);
        drive(0, 1'b0, 64'h0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        sample(0, got, ov, ir);
        check("post-reset idle", longint'(ir), 1);

        foreach (vecs[i]) begin
            run_vec(vecs[i].sel, vecs[i].p, vecs[i].r, 1'b0, (i == 3) ? 5 : 0,
                    $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 60; i++) begin
            sel = i % 2;
            p   = (sel == 0) ? 64'($urandom) : 64'($urandom_range(0, 65535));
            // Bias some vectors toward long regimes.
            if (i % 5 == 4) p = p >> $urandom_range(1, (sel == 0) ? 30 : 14);
            want = ref_decode(p, (sel == 0) ? 32 : 16, (sel == 0) ? 2 : 1);
            run_vec(sel, p, want, bit'($urandom_range(0, 1)), $urandom_range(0, 2),
                    $sformatf("rnd%0d", i));
        end

        // Abort a negative long-regime decode in the middle of the scan.
        @(negedge clk);
        drive(0, 1'b1, 64'h80000001, 1'b0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 64'h0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        sample(0, got, ov, ir);
        check("mid-scan busy", longint'(ir), 0);
        check("mid-scan sign", longint'(got.sign), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        sample(0, got, ov, ir);
        check("abort out_valid", longint'(ov), 0);
        check("abort in_ready", longint'(ir), 1);
        want = ref_decode(64'h0, 32, 2);
        want.zero = 1'b0;
        cmp_fields("abort", got, want);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            sample(0, got, ov, ir);
            if (ov) seen++;
        end
        check("no partial result", longint'(seen), 0);
        run_vec(0, 64'h4C000000, ref_decode(64'h4C000000, 32, 2), 1'b0, 1, "recover");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
